// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the two-port RAM arbiter
package mem_arbiter_pkg;

  // Arbiter FSM states: free arbitration, or one port holding a lock
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  // Port-select encoding used for last_win
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// rtl/mem_arbiter_arb_rr2.sv - two-requester round-robin pick
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic      req_a,
  input  logic      req_b,
  input  port_sel_t last_win,
  output logic      gnt_a,
  output logic      gnt_b
);

  // On contention, favour whichever port did not win most recently
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      if (last_win == PORT_B) gnt_a = 1'b1;
      else                    gnt_b = 1'b1;
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug port arbiter for a single-port RAM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t    state, state_nxt;
  port_sel_t     last_win, last_win_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          rr_gnt_a, rr_gnt_b;
  logic          cap_hit;

  // Lock holder has used its full allowance of consecutive grants
  assign cap_hit = (lock_cnt == CW'(LOCK_MAX));

  arb_rr2 u_rr2 (
    .req_a    (a_req),
    .req_b    (b_req),
    .last_win (last_win),
    .gnt_a    (rr_gnt_a),
    .gnt_b    (rr_gnt_b)
  );

  // State register; reset drops any lock and hands first contention to A
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_win <= PORT_B;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_win <= last_win_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Grant decision and next-state; a lock holder yields once capped and contended
  always_comb begin
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    state_nxt    = state;
    last_win_nxt = last_win;
    lock_cnt_nxt = lock_cnt;

    if (!rst) begin
      unique case (state)
        IDLE: begin
          a_gnt = rr_gnt_a;
          b_gnt = rr_gnt_b;
        end
        LOCK_A: begin
          if (a_req && !(cap_hit && b_req)) a_gnt = 1'b1;
          else                               b_gnt = b_req;
        end
        LOCK_B: begin
          if (b_req && !(cap_hit && a_req)) b_gnt = 1'b1;
          else                               a_gnt = a_req;
        end
        default: ;
      endcase

      if (a_gnt)      last_win_nxt = PORT_A;
      else if (b_gnt) last_win_nxt = PORT_B;

      unique case (state)
        IDLE: begin
          if (a_gnt && a_lock) begin
            state_nxt    = LOCK_A;
            lock_cnt_nxt = CW'(1);
          end else if (b_gnt && b_lock) begin
            state_nxt    = LOCK_B;
            lock_cnt_nxt = CW'(1);
          end
        end
        LOCK_A: begin
          if (a_gnt && a_lock) begin
            if (!cap_hit) lock_cnt_nxt = lock_cnt + CW'(1);
          end else begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end
        end
        LOCK_B: begin
          if (b_gnt && b_lock) begin
            if (!cap_hit) lock_cnt_nxt = lock_cnt + CW'(1);
          end else begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Route the winner's request to the RAM; idle bus is all zeros
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  // Read data returns one cycle after a granted read
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  assign a_rdata = ram_dout;
  assign b_rdata = ram_dout;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 8, meaning RAM address width.
REQ-002 The module SHALL have parameter DW, default 16, meaning RAM data width.
REQ-003 The module SHALL have parameter LOCK_MAX, default 4, meaning maximum consecutive locked grants to one port while the other port waits.
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The module SHALL have ports a_req, a_we, a_lock, input, 1 bit each: CPU port request, write enable, lock.
REQ-008 The module SHALL have ports a_addr (AW) and a_wdata (DW), inputs: CPU port address and write data.
REQ-009 The module SHALL have ports a_gnt and a_rvalid, output, 1 bit each: CPU access granted this cycle; read data valid.
REQ-010 The module SHALL have port a_rdata, output, DW bits: CPU read data.
REQ-011 The module SHALL have ports b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: debug/loader port, same widths and meanings as the a_* ports.
REQ-012 The module SHALL have ports ram_we (1), ram_addr (AW), ram_din (DW), output: single-port RAM controls.
REQ-013 The module SHALL have port ram_dout, input, DW bits: RAM read data, valid one cycle after the address is presented.

Function
REQ-014 Each transaction SHALL be single-beat: requester holds req/we/addr/wdata stable until it samples gnt=1 in the same cycle.
REQ-015 gnt SHALL be combinational from req and registered state; at most one of a_gnt/b_gnt SHALL be 1 per cycle.
REQ-016 State machine SHALL have states IDLE, LOCK_A, LOCK_B.
REQ-017 In IDLE with one req high: grant that port; with both high: grant the port not in register last_win; with none: no grant.
REQ-018 On any grant, last_win SHALL update to the granted port at the clock edge.
REQ-019 IDLE->LOCK_x SHALL occur when port x is granted with x_lock=1; lock_cnt is then loaded with 1.
REQ-020 In LOCK_x, port x SHALL have absolute priority while x_req=1; each grant increments lock_cnt.
REQ-021 LOCK_x->IDLE SHALL occur when x_lock=0 or x_req=0, or when lock_cnt=LOCK_MAX and the other port requests; in the last case the other port SHALL win the next cycle.
REQ-022 Without a competing request, lock_cnt SHALL saturate at LOCK_MAX and the lock SHALL persist.
REQ-023 Winner's we/addr/wdata SHALL drive ram_we/ram_addr/ram_din in the grant cycle; with no grant ram_we=0, ram_addr=0, ram_din=0.
REQ-024 x_rvalid SHALL be a register set to 1 in the cycle after x_gnt=1 with x_we=0, otherwise 0.
REQ-025 a_rdata and b_rdata SHALL both equal ram_dout unconditionally; consumers qualify with rvalid.
REQ-026 Back-to-back grants SHALL be allowed every cycle (throughput 1 access/cycle).

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, last_win=B, lock_cnt=0, a_rvalid=b_rvalid=0.
REQ-028 During rst=1, a_gnt=b_gnt=0 and ram_we=0 regardless of req.
REQ-029 Reset mid-lock SHALL abandon the lock; no rvalid SHALL be produced for a grant preceding the reset edge.

Structure
REQ-030 Shared package SHALL hold the state enumeration (IDLE, LOCK_A, LOCK_B) and the port-select encoding (A=0, B=1).
REQ-031 A sub-module arb_rr2 (two-requester round-robin pick from req pair and last_win) is natural; the FSM and datapath muxing stay in mem_arbiter.

Verification
REQ-032 Release reset, a_req read addr 0x05 alone -> a_gnt same cycle, ram_addr=0x05, a_rvalid next cycle with a_rdata=RAM[5].
REQ-033 a_req and b_req held continuously, no lock -> grants alternate B? no: A,B,A,B (last_win=B after reset).
REQ-034 b_lock=1 with b_req writes to 0x0E..0x13 while a_req held, LOCK_MAX=4 -> four b_gnt, then one a_gnt, then B resumes.
REQ-035 b_lock=1, a_req low -> b_gnt every cycle beyond LOCK_MAX, no rotation.
REQ-036 Write 0x0005 to 0x0E via B, then A reads 0x0E -> a_rdata=0x0005 with a_rvalid; b_rvalid stays 0.
REQ-037 Assert rst during LOCK_B -> next cycle state IDLE, gnts 0, rvalids 0; after release both requesting -> A granted first.
